// File: rtl/matmul_pkg.sv
// ============================================================================
// Module : matmul_pkg
// Shared state encoding and address-width helper for the matmul controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for a dimension of size x; never narrower than one bit.
    function automatic int WX(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_delay.sv
// ============================================================================
// Module : matmul_delay
// DEPTH-stage shift register with hold enable and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module matmul_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/matmul_ctrl.sv
// ============================================================================
// Module : matmul_ctrl
// Address/MAC sequencer for C = A x B (loop order i, column group, k).
// Optional stall input enabled by macro MATMUL_STALL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int M        = 4,
    parameter int N        = 4,
    parameter int K        = 4,
    parameter int LANES    = 1,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MATMUL_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WX(M)-1:0] a_row,
    output logic [WX(K)-1:0] a_col,
    output logic [WX(K)-1:0] b_row,
    output logic [WX(N)-1:0] b_col,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [WX(M)-1:0] c_row,
    output logic [WX(N)-1:0] c_col,
    output logic             c_wen
);

    localparam int WM = WX(M);
    localparam int WN = WX(N);
    localparam int WK = WX(K);
    localparam int G  = N / LANES;
    localparam int WG = WX(G);
    localparam int WD = 4;

    state_t        state, state_nx;
    logic [WM-1:0] i_cnt;
    logic [WG-1:0] g_cnt;
    logic [WK-1:0] k_cnt;
    logic [WD-1:0] drain_cnt;
    logic          adv, issue, k_first, k_last, last_issue;
    logic          mac_v, wen_v;
    logic [WN-1:0] col0;

`ifdef MATMUL_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    assign issue      = (state == RUN);
    assign k_first    = (k_cnt == '0);
    assign k_last     = (k_cnt == WK'(K - 1));
    assign last_issue = issue && k_last && (g_cnt == WG'(G - 1)) && (i_cnt == WM'(M - 1));
    assign col0       = WN'(g_cnt * LANES);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else if (adv) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_issue) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == WD'(PIPE_LAT)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // DRAIN lasts PIPE_LAT+1 cycles so the final write leaves the pipe first.
    always_ff @(posedge clk) begin
        if (reset) drain_cnt <= '0;
        else if (adv) drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end

    // Counters double as the registered addresses; the last issue wraps them to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_cnt <= '0;
            g_cnt <= '0;
            k_cnt <= '0;
        end else if (adv && issue) begin
            if (k_last) begin
                k_cnt <= '0;
                if (g_cnt == WG'(G - 1)) begin
                    g_cnt <= '0;
                    i_cnt <= (i_cnt == WM'(M - 1)) ? '0 : i_cnt + 1'b1;
                end else begin
                    g_cnt <= g_cnt + 1'b1;
                end
            end else begin
                k_cnt <= k_cnt + 1'b1;
            end
        end
    end

    matmul_delay #(.W(2), .DEPTH(PIPE_LAT)) u_mac_dly (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     ({issue, issue & k_first}),
        .q     ({mac_v, mac_clr})
    );

    matmul_delay #(.W(1 + WM + WN), .DEPTH(PIPE_LAT + 1)) u_wr_dly (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     ({issue & k_last, i_cnt, col0}),
        .q     ({wen_v, c_row, c_col})
    );

    assign mac_en = mac_v & adv;
    assign c_wen  = wen_v & adv;
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);
    assign a_row  = i_cnt;
    assign a_col  = k_cnt;
    assign b_row  = k_cnt;
    assign b_col  = col0;

endmodule

`default_nettype wire

// File: tb/tb_matmul_ctrl.sv
// ============================================================================
// Module : tb_matmul_ctrl
// Self-checking bench: default 4x4x4 controller plus a two-lane instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matmul_ctrl;

    localparam int M = 4, N = 4, K = 4, L = 2;
    localparam int G = N;
    localparam int T = M * G * K;

    typedef struct {
        int cyc;
        int row;
        int col;
    } ev_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start1 = 1'b0;
`ifdef MATMUL_STALL_EN
    logic stall = 1'b0;
`endif
    logic       busy, done, mac_en, mac_clr, c_wen;
    logic [1:0] a_row, a_col, b_row, b_col, c_row, c_col;
    logic       busy1, done1, mac_en1, mac_clr1, c_wen1;
    logic [1:0] a_row1, a_col1, b_row1, b_col1, c_row1, c_col1;

    int  n_cmp = 0, n_bad = 0, cyc = 0;
    int  t0 = -100000, end_rel = 0;
    bit  stall_job = 1'b0;
    ev_t sbq[$];
    int  t1 = 0, n_mac1 = 0, n_wen1 = 0, done1_at = -1;
    bit  act1 = 1'b0;

    matmul_ctrl #(.M(M), .N(N), .K(K), .LANES(1), .PIPE_LAT(L)) dut (
        .clk(clk), .reset(reset),
`ifdef MATMUL_STALL_EN
        .stall(stall),
`endif
        .start(start), .busy(busy), .done(done),
        .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .c_row(c_row), .c_col(c_col), .c_wen(c_wen)
    );

    matmul_ctrl #(.M(4), .N(4), .K(4), .LANES(2), .PIPE_LAT(2)) dut2 (
        .clk(clk), .reset(reset),
`ifdef MATMUL_STALL_EN
        .stall(1'b0),
`endif
        .start(start1), .busy(busy1), .done(done1),
        .a_row(a_row1), .a_col(a_col1), .b_row(b_row1), .b_col(b_col1),
        .mac_en(mac_en1), .mac_clr(mac_clr1),
        .c_row(c_row1), .c_col(c_col1), .c_wen(c_wen1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model for the default instance, evaluated every cycle.
    always @(negedge clk) begin
        int r, u, p, q;
        bit stl, iv, qv;
        ev_t e;
        r = cyc - t0;
        stl = stall_job && r >= 10 && r < 15;
        if (stall_job && r >= 10) u = (r < 15) ? 10 : r - 5;
        else u = r;
        if (r > end_rel) u = -1000;
        p  = u - 1;
        q  = u - 1 - L;
        iv = (p >= 0) && (p < T);
        qv = (q >= 0) && (q < T);
        check("busy", busy, (u >= 1 && u <= T + L + 1) ? 1 : 0);
        check("done", done, (u == T + L + 2) ? 1 : 0);
        check("a_row", a_row, iv ? p / (G * K) : 0);
        check("a_col", a_col, iv ? p % K : 0);
        check("b_row", b_row, iv ? p % K : 0);
        check("b_col", b_col, iv ? (p / K) % G : 0);
        check("mac_en", mac_en, (qv && !stl) ? 1 : 0);
        if (!stl) check("mac_clr", mac_clr, (qv && (q % K == 0)) ? 1 : 0);
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            check("c_wen_missed", 0, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (c_wen === 1'b1) begin
            if (sbq.size() == 0) check("c_wen_unexpected", 1, 0);
            else begin
                e = sbq.pop_front();
                check("c_wen_cycle", cyc, e.cyc);
                check("c_row", c_row, e.row);
                check("c_col", c_col, e.col);
            end
        end
    end

    always @(negedge clk) begin
        int r1;
        if (act1) begin
            r1 = cyc - t1;
            if (mac_en1) n_mac1++;
            if (r1 >= 1 && r1 <= 8) check("b_col_l2", b_col1, ((r1 - 1) / 4) * 2);
            if (c_wen1) begin
                check("c_wen_cyc_l2", r1, n_wen1 * 4 + 7);
                check("c_col_l2", c_col1, (n_wen1 % 2) * 2);
                check("c_row_l2", c_row1, n_wen1 / 2);
                n_wen1++;
            end
            if (done1) done1_at = r1;
        end
    end

    task automatic run_job0(input int reset_at, input int extra_start, input bit do_stall);
        int e;
        @(negedge clk);
        t0 = cyc;
        end_rel = 1000;
        stall_job = do_stall;
        for (int p = 0; p < T; p++) begin
            if (p % K == K - 1) begin
                e = p + L + 2;
                if (do_stall && e >= 10) e += 5;
                sbq.push_back('{cyc: t0 + e, row: p / (G * K), col: (p / K) % G});
            end
        end
        start = 1'b1;
        for (int r = 1; r <= 80; r++) begin
            @(negedge clk);
            start = (r == extra_start);
`ifdef MATMUL_STALL_EN
            stall = do_stall && r >= 10 && r < 15;
`endif
            reset = (r == reset_at);
            if (r == reset_at) begin
                end_rel = r;
                while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
            end
        end
    endtask

    initial begin
        // Reset held with start asserted: reset must win.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c_wen", c_wen, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        run_job0(-1, 30, 1'b0);
        run_job0(20, -1, 1'b0);
        check("post_reset_busy", busy, 0);
        run_job0(-1, -1, 1'b0);
`ifdef MATMUL_STALL_EN
        run_job0(-1, -1, 1'b1);
`endif

        @(negedge clk);
        t1 = cyc;
        act1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (50) @(negedge clk);
        act1 = 1'b0;
        check("issues_l2", n_mac1, 32);
        check("c_wen_count_l2", n_wen1, 8);
        check("done_at_l2", done1_at, 36);
        check("sb_leftover", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
